bram_pingpong_ctrl: RTL and testbench

Ping-pong buffer controller that owns two BRAM banks. A streaming producer fills one bank while the NTT engine works in place on the other. Bank ownership is tracked by a per-bank state machine, so producer and consumer never touch the same bank. The block sits between the coefficient loader and the NTT butterfly/address-generator stage.

---
 rtl/ntt_pkg.sv | 13 +
 rtl/bram_pingpong_ctrl_bram.sv | 29 ++
 rtl/bram_pingpong_ctrl.sv | 129 ++++++++++++
 tb/tb_bram_pingpong_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types for the NTT buffering stage: per-bank ownership state and bank count.
package ntt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    BUSY  = 2'd3
  } bank_state_t;

  localparam int NUM_BANKS = 2;

endpackage

// File: rtl/bram_pingpong_ctrl_bram.sv
// Simple dual-port BRAM, read-first, with a registered read port whose output
// register is reset (the array itself is never cleared).
module bram_pingpong_ctrl_bram #(
  parameter int width = 32,
  parameter int len   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [len-1:0]   waddr,
  input  logic [width-1:0] wdata,
  input  logic             re,
  input  logic [len-1:0]   raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [1<<len];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register only updates on a read, so rdata holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong controller: producer fills one BRAM bank while the NTT consumer
// works in place on the other; per-bank state decides who owns which bank.
module bram_pingpong_ctrl
  import ntt_pkg::*;
#(
  parameter int width = 32,
  parameter int len   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic             cons_start,
  output logic             cons_busy,
  output logic             cons_bank,
  input  logic             cons_rd_en,
  input  logic [len-1:0]   cons_raddr,
  output logic [width-1:0] cons_rdata,
  output logic             cons_rvalid,
  input  logic             cons_wen,
  input  logic [len-1:0]   cons_waddr,
  input  logic [width-1:0] cons_wdata,
  input  logic             cons_done,
  output logic [3:0]       bank_state
);

  localparam logic [len-1:0] LAST = '1;

  bank_state_t      state     [NUM_BANKS];
  bank_state_t      state_nxt [NUM_BANKS];
  logic             wp, wp_nxt;
  logic             rp, rp_nxt;
  logic [len-1:0]   wcnt, wcnt_nxt;
  logic             start_nxt;
  logic             accept, busy;
  logic             rd_accept, wr_accept, done_accept;
  logic             rd_bank;
  logic [width-1:0] bank_rdata [NUM_BANKS];

  assign in_ready    = (state[wp] == EMPTY) || (state[wp] == FILL);
  assign accept      = in_valid && in_ready;
  assign busy        = (state[rp] == BUSY);
  assign rd_accept   = cons_rd_en && busy;
  assign wr_accept   = cons_wen && busy;
  assign done_accept = cons_done && busy;

  assign cons_busy  = busy;
  assign cons_bank  = rp;
  assign bank_state = {state[1], state[0]};
  assign cons_rdata = bank_rdata[rd_bank];

  // Producer and consumer only ever touch banks in disjoint states, so both
  // updates can land in the same edge without interfering.
  always_comb begin
    state_nxt = state;
    wp_nxt    = wp;
    rp_nxt    = rp;
    wcnt_nxt  = wcnt;
    start_nxt = 1'b0;
    if (accept) begin
      if (wcnt == LAST) begin
        state_nxt[wp] = FULL;
        wcnt_nxt      = '0;
        wp_nxt        = ~wp;
      end else begin
        state_nxt[wp] = FILL;
        wcnt_nxt      = wcnt + len'(1);
      end
    end
    if (state[rp] == FULL) begin
      state_nxt[rp] = BUSY;
      start_nxt     = 1'b1;
    end else if (done_accept) begin
      state_nxt[rp] = EMPTY;
      rp_nxt        = ~rp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) state[b] <= EMPTY;
      wp          <= 1'b0;
      rp          <= 1'b0;
      wcnt        <= '0;
      cons_start  <= 1'b0;
      cons_rvalid <= 1'b0;
      rd_bank     <= 1'b0;
    end else begin
      state       <= state_nxt;
      wp          <= wp_nxt;
      rp          <= rp_nxt;
      wcnt        <= wcnt_nxt;
      cons_start  <= start_nxt;
      cons_rvalid <= rd_accept;
      if (rd_accept) rd_bank <= rp;
    end
  end

  // Each bank's single write port goes to whichever side currently owns it.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic             cons_side;
    logic             we;
    logic [len-1:0]   waddr;
    logic [width-1:0] wdata;
    logic             re;

    assign cons_side = busy && (rp == 1'(b));
    assign we        = cons_side ? wr_accept : (accept && (wp == 1'(b)));
    assign waddr     = cons_side ? cons_waddr : wcnt;
    assign wdata     = cons_side ? cons_wdata : in_data;
    assign re        = rd_accept && (rp == 1'(b));

    bram_pingpong_ctrl_bram #(
      .width(width),
      .len  (len)
    ) u_bram (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .re   (re),
      .raddr(cons_raddr),
      .rdata(bank_rdata[b])
    );
  end

endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Directed-sequence bench with random data for the ping-pong controller,
// checked against a word-placement model of the two banks.
module tb_bram_pingpong_ctrl;

  localparam int W = 32;
  localparam int L = 3;
  localparam int D = 1 << L;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         cons_start;
  logic         cons_busy;
  logic         cons_bank;
  logic         cons_rd_en;
  logic [L-1:0] cons_raddr;
  logic [W-1:0] cons_rdata;
  logic         cons_rvalid;
  logic         cons_wen;
  logic [L-1:0] cons_waddr;
  logic [W-1:0] cons_wdata;
  logic         cons_done;
  logic [3:0]   bank_state;

  int vectors     = 0;
  int miscompares = 0;

  // Model: the n-th accepted word since reset lands in bank (n/D)%2 at address n%D.
  logic [W-1:0] mem_model [2][D];
  int           n_acc;

  always #5 clk = ~clk;

  bram_pingpong_ctrl #(.width(W), .len(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cons_start (cons_start),
    .cons_busy  (cons_busy),
    .cons_bank  (cons_bank),
    .cons_rd_en (cons_rd_en),
    .cons_raddr (cons_raddr),
    .cons_rdata (cons_rdata),
    .cons_rvalid(cons_rvalid),
    .cons_wen   (cons_wen),
    .cons_waddr (cons_waddr),
    .cons_wdata (cons_wdata),
    .cons_done  (cons_done),
    .bank_state (bank_state)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    in_valid   = 1'b0;
    in_data    = '0;
    cons_rd_en = 1'b0;
    cons_raddr = '0;
    cons_wen   = 1'b0;
    cons_waddr = '0;
    cons_wdata = '0;
    cons_done  = 1'b0;
  endtask

  task automatic recordAccept(input logic [W-1:0] d);
    mem_model[(n_acc / D) % 2][n_acc % D] = d;
    n_acc++;
  endtask

  task automatic pushWord(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    checkOutput("in_ready_push", {31'b0, in_ready}, 1);
    applyStimulus();
    recordAccept(d);
    in_valid = 1'b0;
  endtask

  task automatic readCheck(input int bank, input int addr);
    cons_rd_en = 1'b1;
    cons_raddr = L'(addr);
    applyStimulus();
    cons_rd_en = 1'b0;
    checkOutput("rvalid_read", {31'b0, cons_rvalid}, 1);
    checkOutput($sformatf("rdata_b%0d_a%0d", bank, addr), cons_rdata, mem_model[bank][addr]);
  endtask

  task automatic pulseReset();
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    n_acc = 0;
    applyStimulus();
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] old5;
    rst   = 1'b0;
    n_acc = 0;
    clearInputs();

    // Reset asserted between edges, then released
    #3 rst = 1'b1;
    #20 rst = 1'b0;
    applyStimulus();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 1);
    checkOutput("rst_busy", {31'b0, cons_busy}, 0);
    checkOutput("rst_bank_state", {28'b0, bank_state}, 0);
    checkOutput("rst_rvalid", {31'b0, cons_rvalid}, 0);
    checkOutput("rst_rdata", cons_rdata, 0);
    checkOutput("rst_start", {31'b0, cons_start}, 0);
    checkOutput("rst_cons_bank", {31'b0, cons_bank}, 0);

    // Partial fill of bank0, then consumer strobes while idle
    for (int i = 0; i < 4; i++) pushWord($urandom);
    checkOutput("fill_state", {28'b0, bank_state}, 4'b0001);
    cons_wen   = 1'b1; cons_waddr = 1; cons_wdata = 32'hDEAD_BEEF;
    cons_rd_en = 1'b1; cons_raddr = 1;
    cons_done  = 1'b1;
    applyStimulus();
    clearInputs();
    checkOutput("idle_rvalid", {31'b0, cons_rvalid}, 0);
    checkOutput("idle_state", {28'b0, bank_state}, 4'b0001);
    checkOutput("idle_busy", {31'b0, cons_busy}, 0);

    // Finish bank0 and watch the handover latency
    for (int i = 4; i < 8; i++) pushWord($urandom);
    checkOutput("full_state", {28'b0, bank_state}, 4'b0010);
    checkOutput("full_start", {31'b0, cons_start}, 0);
    checkOutput("full_busy", {31'b0, cons_busy}, 0);
    applyStimulus();
    checkOutput("start_pulse", {31'b0, cons_start}, 1);
    checkOutput("start_busy", {31'b0, cons_busy}, 1);
    checkOutput("start_bank", {31'b0, cons_bank}, 0);
    checkOutput("start_state", {28'b0, bank_state}, 4'b0011);
    applyStimulus();
    checkOutput("start_fall", {31'b0, cons_start}, 0);
    for (int a = 0; a < D; a++) readCheck(0, a);
    applyStimulus();
    checkOutput("rvalid_idle", {31'b0, cons_rvalid}, 0);
    checkOutput("rdata_hold", cons_rdata, mem_model[0][D-1]);

    // In-place write then read, and read-first on a same-cycle collision
    d = $urandom;
    cons_wen = 1'b1; cons_waddr = 3; cons_wdata = d;
    applyStimulus();
    cons_wen = 1'b0;
    mem_model[0][3] = d;
    readCheck(0, 3);
    d    = $urandom;
    old5 = mem_model[0][5];
    cons_wen = 1'b1; cons_waddr = 5; cons_wdata = d;
    cons_rd_en = 1'b1; cons_raddr = 5;
    applyStimulus();
    clearInputs();
    checkOutput("rf_rvalid", {31'b0, cons_rvalid}, 1);
    checkOutput("rf_old_data", cons_rdata, old5);
    mem_model[0][5] = d;
    readCheck(0, 5);

    // Fill bank1 while bank0 is held: full back-pressure
    for (int i = 0; i < 8; i++) pushWord($urandom);
    checkOutput("bp_state", {28'b0, bank_state}, 4'b1011);
    checkOutput("bp_ready", {31'b0, in_ready}, 0);
    d = $urandom;
    in_valid = 1'b1; in_data = d;
    applyStimulus();
    checkOutput("bp_ready_hold", {31'b0, in_ready}, 0);
    cons_done = 1'b1;
    applyStimulus();
    cons_done = 1'b0;
    checkOutput("rel_ready", {31'b0, in_ready}, 1);
    checkOutput("rel_busy", {31'b0, cons_busy}, 0);
    checkOutput("rel_bank", {31'b0, cons_bank}, 1);
    checkOutput("rel_state", {28'b0, bank_state}, 4'b1000);
    applyStimulus();
    recordAccept(d);
    in_valid = 1'b0;
    checkOutput("b1_start", {31'b0, cons_start}, 1);
    checkOutput("b1_bank", {31'b0, cons_bank}, 1);
    checkOutput("b1_state", {28'b0, bank_state}, 4'b1101);
    for (int a = 0; a < D; a++) readCheck(1, a);

    // Last producer accept and cons_done in the same edge
    for (int i = 0; i < 6; i++) pushWord($urandom);
    d = $urandom;
    in_valid = 1'b1; in_data = d; cons_done = 1'b1;
    checkOutput("sim_ready", {31'b0, in_ready}, 1);
    applyStimulus();
    recordAccept(d);
    clearInputs();
    checkOutput("sim_state", {28'b0, bank_state}, 4'b0010);
    checkOutput("sim_bank", {31'b0, cons_bank}, 0);
    checkOutput("sim_ready_after", {31'b0, in_ready}, 1);
    applyStimulus();
    checkOutput("sim_start", {31'b0, cons_start}, 1);
    checkOutput("sim_state2", {28'b0, bank_state}, 4'b0011);
    readCheck(0, 0);
    readCheck(0, D-1);

    // Partial fill of bank1, then reset mid-operation
    cons_done = 1'b1;
    applyStimulus();
    cons_done = 1'b0;
    checkOutput("drain_state", {28'b0, bank_state}, 4'b0000);
    for (int i = 0; i < 5; i++) pushWord($urandom);
    checkOutput("part_state", {28'b0, bank_state}, 4'b0100);
    pulseReset();
    checkOutput("rst2_state", {28'b0, bank_state}, 0);
    checkOutput("rst2_ready", {31'b0, in_ready}, 1);
    checkOutput("rst2_busy", {31'b0, cons_busy}, 0);
    checkOutput("rst2_bank", {31'b0, cons_bank}, 0);
    for (int i = 0; i < 8; i++) pushWord(W'(32'h10 + i));
    applyStimulus();
    checkOutput("rst2_start", {31'b0, cons_start}, 1);
    checkOutput("rst2_cbank", {31'b0, cons_bank}, 0);
    readCheck(0, 0);
    readCheck(0, 4);
    readCheck(0, 7);
    checkOutput("rst2_first_word", mem_model[0][0], 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
